wall_drawer: RTL and testbench

Renders the moving wall onto the 160x120 VGA frame buffer. Each game tick, the controller hands it the wall datapath's current `wall_x` and hole top `hole_y`. It first erases the wall's previous footprint, then draws the new wall column band with the hole cut out, streaming one pixel per cycle to the VGA adapter's `x/y/colour/plot` inputs. It is the consumer of the wall datapath's position output and has a fixed-latency start/done handshake toward the game FSM.

---
 rtl/wall_pkg.sv | 25 ++
 rtl/wall_drawer_if.sv | 26 ++
 rtl/pixel_scan_counter.sv | 54 +++++
 rtl/wall_drawer.sv | 107 ++++++++++
 tb/tb_wall_drawer.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/wall_pkg.sv
// Shared constants for the wall game: screen geometry, wall shape, colours and
// the drawer's state encoding.
package wall_pkg;

    localparam int unsigned SCREEN_W    = 160;
    localparam int unsigned SCREEN_H    = 120;
    localparam int unsigned WALL_WIDTH  = 4;
    localparam int unsigned HOLE_HEIGHT = 50;

    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] WALL_COLOUR = 3'b010;
    localparam logic [COLOUR_W-1:0] BG_COLOUR   = 3'b000;

    // Column value meaning "no wall on screen"; used as prev_x after reset.
    localparam logic [X_W-1:0] NO_WALL_X = X_W'(SCREEN_W);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StErase = 2'd1;
    localparam logic [1:0] StDraw  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

endpackage

// File: rtl/wall_drawer_if.sv
// Request/handshake and pixel-stream signals between the game controller,
// the wall drawer and the VGA adapter.
interface wall_drawer_if;
    import wall_pkg::*;

    logic                start;
    logic [X_W-1:0]      wall_x;
    logic [Y_W-1:0]      hole_y;
    logic                busy;
    logic                done;
    logic [X_W-1:0]      x_out;
    logic [Y_W-1:0]      y_out;
    logic [COLOUR_W-1:0] colour;
    logic                plot;

    modport master (
        output start, wall_x, hole_y,
        input  busy, done, x_out, y_out, colour, plot
    );

    modport slave (
        input  start, wall_x, hole_y,
        output busy, done, x_out, y_out, colour, plot
    );

endinterface

// File: rtl/pixel_scan_counter.sv
// Nested column/row scan counter: row is the inner loop, column the outer.
// Synchronous clear has priority over enable; last flags the final pixel.
module pixel_scan_counter #(
    parameter int unsigned COLS = 4,
    parameter int unsigned ROWS = 120,
    parameter int unsigned CW   = $clog2(COLS),
    parameter int unsigned RW   = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last
);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          row_wrap;

    assign row_wrap = (row_q == RW'(ROWS - 1));
    assign last     = row_wrap && (col_q == CW'(COLS - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (enable) begin
            if (row_wrap) begin
                row_d = '0;
                col_d = last ? '0 : col_q + CW'(1);
            end else begin
                row_d = row_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col = col_q;
    assign row = row_q;

endmodule

// File: rtl/wall_drawer.sv
// Erases the previous wall band then draws the new one with its hole,
// streaming one registered pixel per clock to the VGA adapter.
module wall_drawer
    import wall_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    wall_drawer_if.slave  bus
);

    localparam int unsigned CW = $clog2(WALL_WIDTH);
    localparam int unsigned RW = $clog2(SCREEN_H);

    logic [1:0]          state_q, state_d;
    logic [X_W-1:0]      cur_x_q, prev_x_q;
    logic [Y_W-1:0]      cur_hole_q;

    logic                busy_q, done_q, plot_q;
    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic [COLOUR_W-1:0] colour_q;

    logic [CW-1:0]       c;
    logic [RW-1:0]       r;
    logic                last, clear, active;
    logic [X_W-1:0]      base_x;
    logic [X_W:0]        col_sum;
    logic [Y_W:0]        hole_end;
    logic                in_hole;

    assign active  = (state_q == StErase) || (state_q == StDraw);
    assign clear   = ((state_q == StIdle) && bus.start) || ((state_q == StErase) && last);

    pixel_scan_counter #(
        .COLS (WALL_WIDTH),
        .ROWS (SCREEN_H)
    ) u_scan (
        .clk    (clk),
        .resetn (resetn),
        .clear  (clear),
        .enable (active),
        .col    (c),
        .row    (r),
        .last   (last)
    );

    // Column sum is one bit wider so columns past 255 can never alias on-screen.
    assign base_x   = (state_q == StDraw) ? cur_x_q : prev_x_q;
    assign col_sum  = {1'b0, base_x} + {{(X_W + 1 - CW){1'b0}}, c};
    assign hole_end = {1'b0, cur_hole_q} + (Y_W + 1)'(HOLE_HEIGHT);
    assign in_hole  = ({1'b0, r} >= {1'b0, cur_hole_q}) && ({1'b0, r} < hole_end);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StErase;
            StErase: if (last)      state_d = StDraw;
            StDraw:  if (last)      state_d = StDone;
            StDone:                 state_d = StIdle;
            default:                state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            cur_x_q    <= '0;
            cur_hole_q <= '0;
            prev_x_q   <= NO_WALL_X;
        end else begin
            state_q <= state_d;
            if ((state_q == StIdle) && bus.start) begin
                cur_x_q    <= bus.wall_x;
                cur_hole_q <= bus.hole_y;
            end
            if (state_q == StDone) begin
                prev_x_q <= cur_x_q;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            plot_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
        end else begin
            busy_q   <= active;
            done_q   <= (state_q == StDone);
            plot_q   <= active && (col_sum < (X_W + 1)'(SCREEN_W));
            x_q      <= active ? col_sum[X_W-1:0] : '0;
            y_q      <= active ? r : '0;
            colour_q <= ((state_q == StDraw) && !in_hole) ? WALL_COLOUR : BG_COLOUR;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.plot   = plot_q;
    assign bus.x_out  = x_q;
    assign bus.y_out  = y_q;
    assign bus.colour = colour_q;

endmodule

// File: tb/tb_wall_drawer.sv
// Self-checking bench for wall_drawer: table of frames plus random frames,
// compared pixel by pixel against a frame-level model of the wall rendering.
module tb_wall_drawer;
    import wall_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    wall_drawer_if bus();

    wall_drawer dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        int wx;
        int hy;
        int inject;     // pixel index at which to pulse start mid-redraw, -1 for none
        int exp_erase;  // expected plots in the erase phase
        int exp_draw;   // expected plots in the draw phase
    } vec_t;

    vec_t vecs[8];
    int checks = 0;
    int errors = 0;
    int model_prev = 160;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    function automatic int band_plots(input int base);
        int n = 0;
        for (int c = 0; c < 4; c++) if (base + c < 160) n += 120;
        return n;
    endfunction

    task automatic run_frame(input int wx, input int hy, input int inject,
                             input int exp_erase, input int exp_draw, input string tag);
        int bad, first_bad, ne, nd;
        int phase, j, col, row, e_plot, e_colour, base;
        bad = 0; first_bad = -1; ne = 0; nd = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.wall_x = 8'(wx); bus.hole_y = 7'(hy);
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int i = 0; i < 960; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == inject) bus.start = 1'b1;
            else if (i == inject + 1) bus.start = 1'b0;
            phase    = i / 480;
            j        = i % 480;
            base     = (phase == 0) ? model_prev : wx;
            col      = base + j / 120;
            row      = j % 120;
            e_plot   = (col < 160) ? 1 : 0;
            e_colour = (phase == 1 && !(row >= hy && row < hy + 50)) ? 2 : 0;
            if ($isunknown({bus.x_out, bus.y_out, bus.colour, bus.plot, bus.busy, bus.done})
                || bus.plot !== 1'(e_plot) || bus.x_out !== 8'(col) || bus.y_out !== 7'(row)
                || bus.colour !== 3'(e_colour) || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                if (bad == 0) first_bad = i;
                bad++;
            end
            if (bus.plot === 1'b1) begin
                if (phase == 0) ne++;
                else nd++;
            end
        end
        if (bad != 0) $display("  %s: first bad pixel index %0d", tag, first_bad);
        check({tag, " bad pixels"}, bad, 0);
        check({tag, " erase plots"}, ne, (exp_erase >= 0) ? exp_erase : band_plots(model_prev));
        check({tag, " draw plots"}, nd, (exp_draw >= 0) ? exp_draw : band_plots(wx));
        @(posedge clk);
        @(negedge clk);
        check({tag, " done at k+961"}, int'(bus.done), 1);
        check({tag, " busy low at done"}, int'(bus.busy), 0);
        check({tag, " plot low at done"}, int'(bus.plot), 0);
        model_prev = wx;
        @(negedge clk);
        check({tag, " done one cycle"}, int'(bus.done), 0);
    endtask

    initial begin
        vecs[0] = '{wx: 100, hy: 30,  inject: -1,  exp_erase: 0,   exp_draw: 480};
        vecs[1] = '{wx: 96,  hy: 60,  inject: -1,  exp_erase: 480, exp_draw: 480};
        vecs[2] = '{wx: 158, hy: 10,  inject: -1,  exp_erase: 480, exp_draw: 240};
        vecs[3] = '{wx: 50,  hy: 100, inject: -1,  exp_erase: 240, exp_draw: 480};
        vecs[4] = '{wx: 20,  hy: 10,  inject: 300, exp_erase: 480, exp_draw: 480};
        vecs[5] = '{wx: 160, hy: 5,   inject: -1,  exp_erase: 480, exp_draw: 0};
        vecs[6] = '{wx: 0,   hy: 0,   inject: -1,  exp_erase: 0,   exp_draw: 480};
        vecs[7] = '{wx: 156, hy: 119, inject: -1,  exp_erase: 480, exp_draw: 480};

        bus.start = 1'b0; bus.wall_x = '0; bus.hole_y = '0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset plot", int'(bus.plot), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        check("reset x_out", int'(bus.x_out), 0);
        check("reset colour", int'(bus.colour), 0);
        resetn = 1'b1;
        model_prev = 160;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            run_frame(vecs[v].wx, vecs[v].hy, vecs[v].inject,
                      vecs[v].exp_erase, vecs[v].exp_draw, $sformatf("vec%0d", v));
            if (vecs[v].inject >= 0) begin
                int stray = 0;
                repeat (6) begin
                    @(negedge clk);
                    if (bus.busy !== 1'b0 || bus.done !== 1'b0) stray++;
                end
                check($sformatf("vec%0d ignored start", v), stray, 0);
            end
        end

        for (int n = 0; n < 5; n++) begin
            run_frame(int'($urandom_range(0, 160)), int'($urandom_range(0, 119)), -1, -1, -1,
                      $sformatf("rand%0d", n));
        end

        // Asynchronous reset in the middle of the draw phase (pixel 200 of DRAW).
        @(negedge clk);
        bus.start = 1'b1; bus.wall_x = 8'd40; bus.hole_y = 7'd20;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (681) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("async reset plot", int'(bus.plot), 0);
        check("async reset busy", int'(bus.busy), 0);
        check("async reset done", int'(bus.done), 0);
        @(negedge clk);
        resetn = 1'b1;
        model_prev = 160;
        @(negedge clk);
        check("after reset busy", int'(bus.busy), 0);
        run_frame(70, 40, -1, 0, 480, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
